// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite table DMA.
//   - sprite geometry constants
//   - descriptor field positions and the packed descriptor struct
//   - DMA state encoding
package sprite_pkg;

  localparam int SPRITE_NUM    = 8;
  localparam int SPRITE_WIDTH  = 30;
  localparam int SPRITE_HEIGHT = 50;

  // Descriptor field bit positions
  localparam int X_MSB      = 31;
  localparam int X_LSB      = 22;
  localparam int Y_MSB      = 21;
  localparam int Y_LSB      = 12;
  localparam int HIDE_BIT   = 11;
  localparam int STATUS_MSB = 8;
  localparam int STATUS_LSB = 7;
  localparam int POSE_MSB   = 6;
  localparam int POSE_LSB   = 0;

  // x value beyond the 640-pixel line, so the renderer draws nothing
  localparam logic [9:0] X_OFFSCREEN = 10'h3FF;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hide;
    logic [1:0] rsvd;
    logic [1:0] status;
    logic [6:0] pose;
  } sprite_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } dma_state_t;

endpackage

// File: rtl/sprite_desc_mask.sv
// sprite_desc_mask: combinational hide rule for one descriptor word.
//   i_word : descriptor as read from source RAM
//   o_word : descriptor to write to the renderer; hidden sprites get
//            x = 10'h3FF and the hide bit cleared, other bits untouched.
module sprite_desc_mask
  import sprite_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  sprite_desc_t w_in;
  sprite_desc_t w_out;

  assign w_in = i_word;

  // Move hidden sprites off-screen; the renderer has no hide bit of its own
  always_comb begin
    w_out = w_in;
    if (w_in.hide) begin
      w_out.x    = X_OFFSCREEN;
      w_out.hide = 1'b0;
    end else begin
      w_out = w_in;
    end
  end

  assign o_word = w_out;

endmodule

// File: rtl/sprite_table_dma.sv
// sprite_table_dma: per-frame copy of SPRITE_NUM descriptors from source
// RAM to the sprite renderer register file over Avalon-MM.
//   CLK, RESET_N         : clock, asynchronous active-low reset
//   frame_start, enable  : start pulse and its qualifier
//   M_*                  : Avalon-MM master (word addressing)
//   busy                 : high from the first request through DONE
//   done                 : one-cycle pulse after the last write is accepted
//   overrun, overrun_clr : sticky flag for a start request while busy, and its clear
module sprite_table_dma
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] SRC_BASE   = 16'h0100,
  parameter logic [ADDR_W-1:0] DST_BASE   = 16'h0000,
  parameter int                SPRITE_NUM = 8
)(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              frame_start,
  input  logic              enable,
  output logic [ADDR_W-1:0] M_ADDRESS,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [3:0]        M_BYTEENABLE,
  output logic [31:0]       M_WRITEDATA,
  input  logic [31:0]       M_READDATA,
  input  logic              M_READDATAVALID,
  input  logic              M_WAITREQUEST,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  input  logic              overrun_clr
);
  import sprite_pkg::dma_state_t;
  import sprite_pkg::ST_IDLE;
  import sprite_pkg::ST_RD_REQ;
  import sprite_pkg::ST_RD_WAIT;
  import sprite_pkg::ST_WR_REQ;
  import sprite_pkg::ST_DONE;

  localparam logic [2:0] LAST_IDX = 3'(SPRITE_NUM - 1);

  dma_state_t        r_state;
  logic [2:0]        r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic              r_read;
  logic              r_write;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_overrun;
  logic [31:0]       w_masked;
  logic [2:0]        w_idx_inc;
  logic              w_start;

  assign w_idx_inc = r_idx + 3'd1;
  assign w_start   = frame_start & enable;

  sprite_desc_mask u_mask (
    .i_word (M_READDATA),
    .o_word (w_masked)
  );

  // Transfer sequencer; all bus outputs are registered so address and data
  // only change on state transitions and stay put while the slave stalls
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_idx   <= 3'd0;
            r_addr  <= SRC_BASE;
            r_read  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_RD_REQ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if (!M_WAITREQUEST) begin
            r_read  <= 1'b0;
            r_state <= ST_RD_WAIT;
          end else begin
            r_state <= ST_RD_REQ;
          end
        end
        ST_RD_WAIT: begin
          if (M_READDATAVALID) begin
            r_wdata <= w_masked;
            r_addr  <= DST_BASE + ADDR_W'(r_idx);
            r_write <= 1'b1;
            r_state <= ST_WR_REQ;
          end else begin
            r_state <= ST_RD_WAIT;
          end
        end
        ST_WR_REQ: begin
          if (!M_WAITREQUEST) begin
            r_write <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_idx   <= w_idx_inc;
              r_addr  <= SRC_BASE + ADDR_W'(w_idx_inc);
              r_read  <= 1'b1;
              r_state <= ST_RD_REQ;
            end
          end else begin
            r_state <= ST_WR_REQ;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_overrun <= 1'b0;
    end else if (w_start && r_busy) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign M_ADDRESS    = r_addr;
  assign M_READ       = r_read;
  assign M_WRITE      = r_write;
  assign M_BYTEENABLE = 4'b1111;
  assign M_WRITEDATA  = r_wdata;
  assign busy         = r_busy;
  assign done         = r_done;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sprite_table_dma.sv
// Testbench for sprite_table_dma: Avalon slave model with programmable
// wait states and read latency 1, write scoreboard, table-driven transfers
// plus hand-written overrun, enable and reset sequences.
module tb_sprite_table_dma;

  localparam logic [15:0] SRC = 16'h0100;
  localparam logic [15:0] DST = 16'h0000;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        frame_start = 1'b0;
  logic        enable = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [15:0] M_ADDRESS;
  logic        M_READ;
  logic        M_WRITE;
  logic [3:0]  M_BYTEENABLE;
  logic [31:0] M_WRITEDATA;
  logic [31:0] M_READDATA;
  logic        M_READDATAVALID;
  logic        M_WAITREQUEST;
  logic        busy;
  logic        done;
  logic        overrun;

  sprite_table_dma dut (
    .CLK (CLK), .RESET_N (RESET_N), .frame_start (frame_start), .enable (enable),
    .M_ADDRESS (M_ADDRESS), .M_READ (M_READ), .M_WRITE (M_WRITE),
    .M_BYTEENABLE (M_BYTEENABLE), .M_WRITEDATA (M_WRITEDATA),
    .M_READDATA (M_READDATA), .M_READDATAVALID (M_READDATAVALID),
    .M_WAITREQUEST (M_WAITREQUEST), .busy (busy), .done (done),
    .overrun (overrun), .overrun_clr (overrun_clr)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] src; logic [31:0] exp; } wvec_t;
  typedef struct { int stall; int set; int exp_done; } scen_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;

  wvec_t       words [2][8];
  scen_t       scen [3];
  wr_t         sb [$];
  logic [31:0] mem [8];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int stall_n = 0;
  int wcnt = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, busy_seen = 0;
  int both_err = 0, stab_err = 0;
  logic [15:0] first_rd_addr = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave wait-state generator: each request stalls stall_n cycles
  assign M_WAITREQUEST = (M_READ || M_WRITE) && (wcnt < stall_n);

  initial begin
    forever begin
      @(posedge CLK);
      cyc <= cyc + 1;
    end
  end

  // Slave: counts stall cycles, returns read data one cycle after acceptance
  initial begin
    logic [15:0] off;
    M_READDATA = 32'h0;
    M_READDATAVALID = 1'b0;
    forever begin
      @(posedge CLK);
      if (!RESET_N) begin
        wcnt <= 0;
        M_READDATAVALID <= 1'b0;
      end else begin
        if (M_READ || M_WRITE) begin
          if (wcnt < stall_n) wcnt <= wcnt + 1;
          else wcnt <= 0;
        end
        if (M_READ && !M_WAITREQUEST) begin
          off = M_ADDRESS - SRC;
          M_READDATA <= mem[off[2:0]];
          M_READDATAVALID <= 1'b1;
        end else begin
          M_READDATAVALID <= 1'b0;
        end
      end
    end
  end

  // Bus monitor: protocol rules, request counts, scoreboard on accepted writes
  initial begin
    logic        prev_wait;
    logic        prev_rd;
    logic        prev_wr;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;
    wr_t         e;
    prev_wait = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
    prev_addr = 16'h0; prev_data = 32'h0;
    forever begin
      @(negedge CLK);
      if (M_READ && M_WRITE) both_err++;
      if (prev_wait && RESET_N) begin
        if (M_ADDRESS !== prev_addr || M_READ !== prev_rd || M_WRITE !== prev_wr ||
            (prev_wr && M_WRITEDATA !== prev_data)) stab_err++;
      end
      prev_wait = M_WAITREQUEST; prev_rd = M_READ; prev_wr = M_WRITE;
      prev_addr = M_ADDRESS; prev_data = M_WRITEDATA;
      if (busy) busy_seen++;
      if (done) done_cnt++;
      if (M_READ && !M_WAITREQUEST) begin
        if (rd_cnt == 0) first_rd_addr = M_ADDRESS;
        rd_cnt++;
      end
      if (M_WRITE && !M_WAITREQUEST) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(M_ADDRESS), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(M_ADDRESS), 32'(e.addr));
          chk("wr_data", M_WRITEDATA, e.data);
        end
      end
    end
  end

  task automatic clr_cnt();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_seen = 0;
  endtask

  // Load source RAM from a word set and queue the expected writes
  task automatic load_set(input int set);
    for (int i = 0; i < 8; i++) begin
      wr_t w;
      mem[i] = words[set][i].src;
      w.addr = DST + 16'(i);
      w.data = words[set][i].exp;
      sb.push_back(w);
    end
  endtask

  task automatic pulse(input logic clr, input logic mark);
    @(negedge CLK);
    frame_start = 1'b1;
    overrun_clr = clr;
    if (mark) start_cyc = cyc;
    @(negedge CLK);
    frame_start = 1'b0;
    overrun_clr = 1'b0;
  endtask

  // Wait for done (bounded); returns cycle of done relative to frame_start
  task automatic wait_done(output int rel);
    bit seen;
    seen = 1'b0;
    rel = -1;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (done) begin
        seen = 1'b1;
        rel = cyc - start_cyc;
      end else begin
        @(negedge CLK);
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int rel;
    // word set 0: plain copy; set 1: mixes hidden and visible sprites
    for (int i = 0; i < 8; i++) begin
      words[0][i].src = 32'h0280_5003 + 32'(i);
      words[0][i].exp = 32'h0280_5003 + 32'(i);
      words[1][i].src = 32'h0280_5003 + 32'(i);
      words[1][i].exp = 32'h0280_5003 + 32'(i);
    end
    words[1][0].src = 32'h0000_0180; words[1][0].exp = 32'h0000_0180;
    words[1][3].src = 32'h0A06_4805; words[1][3].exp = 32'hFFC6_4005;
    words[1][5].src = 32'hFFFF_FFFF; words[1][5].exp = 32'hFFFF_F7FF;
    words[1][6].src = 32'h0000_0800; words[1][6].exp = 32'hFFC0_0000;
    // Zero wait: 8 x (1 + 1 + 1) = 24 cycles, done in 25.
    // Three stall cycles per request: 8 x (4 + 1 + 4) = 72 cycles, done in 73.
    scen[0] = '{stall: 0, set: 0, exp_done: 25};
    scen[1] = '{stall: 0, set: 1, exp_done: 25};
    scen[2] = '{stall: 3, set: 1, exp_done: 73};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_read", 32'(M_READ), 32'd0);
    chk("rst_write", 32'(M_WRITE), 32'd0);
    chk("rst_addr", 32'(M_ADDRESS), 32'd0);
    chk("rst_wdata", M_WRITEDATA, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("byteenable", 32'(M_BYTEENABLE), 32'hF);
    RESET_N = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge CLK);

    // Table-driven transfers
    for (int s = 0; s < 3; s++) begin
      clr_cnt();
      stall_n = scen[s].stall;
      load_set(scen[s].set);
      pulse(1'b0, 1'b1);
      wait_done(rel);
      chk("done_cycle", 32'(rel), 32'(scen[s].exp_done));
      chk("busy_at_done", 32'(busy), 32'd1);
      @(negedge CLK);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("reads", 32'(rd_cnt), 32'd8);
      chk("writes", 32'(wr_cnt), 32'd8);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      repeat (2) @(negedge CLK);
    end
    stall_n = 0;

    // Overrun: second start at cycle 10 is ignored but flagged
    clr_cnt();
    chk("ovr_before", 32'(overrun), 32'd0);
    load_set(0);
    pulse(1'b0, 1'b1);
    repeat (8) @(negedge CLK);
    pulse(1'b0, 1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    wait_done(rel);
    chk("ovr_done_cycle", 32'(rel), 32'd25);
    repeat (30) @(negedge CLK);
    chk("ovr_writes", 32'(wr_cnt), 32'd8);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    // New overrun with a simultaneous clear: set wins
    clr_cnt();
    load_set(1);
    pulse(1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    pulse(1'b1, 1'b0);
    chk("ovr_set_wins", 32'(overrun), 32'd1);
    wait_done(rel);
    repeat (3) @(negedge CLK);
    chk("ovr2_writes", 32'(wr_cnt), 32'd8);
    overrun_clr = 1'b1;
    @(negedge CLK);
    overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // enable low: start pulse ignored entirely
    clr_cnt();
    enable = 1'b0;
    pulse(1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    chk("dis_reads", 32'(rd_cnt), 32'd0);
    chk("dis_busy", 32'(busy_seen), 32'd0);
    chk("dis_overrun", 32'(overrun), 32'd0);
    enable = 1'b1;

    // Reset just after the 4th write is accepted
    clr_cnt();
    load_set(0);
    pulse(1'b0, 1'b1);
    for (int k = 0; k < 100 && wr_cnt < 4; k++) begin
      @(negedge CLK);
      #1;
    end
    chk("rst_mid_writes", 32'(wr_cnt), 32'd4);
    @(posedge CLK);
    #2;
    chk("read_before_rst", 32'(M_READ), 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("async_read", 32'(M_READ), 32'd0);
    chk("async_write", 32'(M_WRITE), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    sb.delete();
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    clr_cnt();
    load_set(1);
    pulse(1'b0, 1'b1);
    wait_done(rel);
    chk("post_rst_done", 32'(rel), 32'd25);
    repeat (2) @(negedge CLK);
    chk("post_rst_first_addr", 32'(first_rd_addr), 32'(SRC));
    chk("post_rst_writes", 32'(wr_cnt), 32'd8);
    chk("post_rst_sb", 32'(sb.size()), 32'd0);

    chk("rd_wr_exclusive", 32'(both_err), 32'd0);
    chk("stall_stable", 32'(stab_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
